bus_arbiter_rr: RTL and testbench

//  Round-robin arbiter for the shared master/slave bus. Resolves up to four

---
 rtl/bus_arbiter_rr.sv | 90 +++++++++
 tb/tb_bus_arbiter_rr.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Four-master round-robin bus arbiter with a hold quantum and a lock override.
// All outputs are registered. A grant appears one cycle after req is sampled.
module bus_arbiter_rr #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [3:0]       lock,
  output logic [3:0]       grant,
  output logic             grant_valid,
  output logic [1:0]       grant_id,
  output logic             handover,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] last;
  logic [3:0] others;
  logic       take;
  logic       rel;
  logic [1:0] sel;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  assign others = req & ~grant;

  always_comb begin
    take = 1'b0;
    rel  = 1'b0;
    sel  = rr_pick(req, last);
    if (state == IDLE) begin
      take = |req;
    end else if (!req[grant_id]) begin
      if (|others) begin
        take = 1'b1;
        sel  = rr_pick(others, last);
      end else begin
        rel = 1'b1;
      end
    end else if (|others && !lock[grant_id] && hold_cnt == HOLD_MAX) begin
      take = 1'b1;
      sel  = rr_pick(others, last);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 2'd3;
      grant       <= 4'b0000;
      grant_valid <= 1'b0;
      grant_id    <= 2'd0;
      handover    <= 1'b0;
      hold_cnt    <= '0;
    end else if (take) begin
      state       <= GRANT;
      last        <= sel;
      grant       <= 4'b0001 << sel;
      grant_valid <= 1'b1;
      grant_id    <= sel;
      handover    <= 1'b1;
      hold_cnt    <= '0;
    end else if (rel) begin
      state       <= IDLE;
      grant       <= 4'b0000;
      grant_valid <= 1'b0;
      grant_id    <= 2'd0;
      handover    <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      handover <= 1'b0;
      if (state == GRANT && hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr; expectations are hand-derived per scenario.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       handover;
  logic [3:0] hold_cnt;

  int checks = 0;
  int errors = 0;

  bus_arbiter_rr #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .handover(handover), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output check for a granted owner (or idle when g == 0).
  task automatic chk_out(input string tag, input logic [3:0] g, input logic ho,
                         input int hc);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) id = 2'(i);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(|g));
    chk({tag, ".id"}, 32'(grant_id), 32'(id));
    chk({tag, ".handover"}, 32'(handover), 32'(ho));
    chk({tag, ".hold"}, 32'(hold_cnt), 32'(hc));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    lock  = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b1111;
    lock  = 4'b0000;

    // 1: outputs stay zero under reset even with requests pending
    tick();
    chk_out("t1_rst0", 4'b0000, 1'b0, 0);
    tick();
    chk_out("t1_rst1", 4'b0000, 1'b0, 0);
    reset = 1'b0;
    tick();
    chk_out("t1_first", 4'b0001, 1'b1, 0);

    // 2: two contenders alternate on 8-cycle quanta
    do_reset();
    req = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_out($sformatf("t2_m0_%0d", c), 4'b0001, c == 0, c);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_out($sformatf("t2_m2_%0d", c), 4'b0100, c == 0, c);
    end
    tick();
    chk_out("t2_back", 4'b0001, 1'b1, 0);

    // 3: lock blocks preemption; release hands over directly
    do_reset();
    req  = 4'b0011;
    lock = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_out($sformatf("t3_lock_%0d", c), 4'b0001, c == 0, (c > 7) ? 7 : c);
    end
    req = 4'b0010;
    tick();
    chk_out("t3_release", 4'b0010, 1'b1, 0);

    // 4: owners drop after 3 cycles; order 0,1,2,3,0 without idle gaps
    do_reset();
    req = 4'b1111;
    tick();
    chk_out("t4_own0", 4'b0001, 1'b1, 0);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk_out($sformatf("t4_h1_%0d", n), 4'b0001 << n, 1'b0, 1);
      tick();
      chk_out($sformatf("t4_h2_%0d", n), 4'b0001 << n, 1'b0, 2);
      req = 4'b1111 & ~(4'b0001 << n);
      tick();
      chk_out($sformatf("t4_next_%0d", n), 4'b0001 << ((n + 1) % 4), 1'b1, 0);
      req = 4'b1111;
    end

    // 5: sole requester holds indefinitely; release goes idle silently
    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 30; c++) begin
      tick();
      chk_out($sformatf("t5_solo_%0d", c), 4'b1000, c == 0, (c > 7) ? 7 : c);
    end
    req = 4'b0000;
    tick();
    chk_out("t5_idle", 4'b0000, 1'b0, 0);

    // 6: reset mid-grant drops grant and restores the pointer
    do_reset();
    req = 4'b0010;
    tick();
    chk_out("t6_pre", 4'b0010, 1'b1, 0);
    tick();
    chk_out("t6_hold", 4'b0010, 1'b0, 1);
    reset = 1'b1;
    req   = 4'b0110;
    tick();
    chk_out("t6_rst", 4'b0000, 1'b0, 0);
    reset = 1'b0;
    tick();
    chk_out("t6_after", 4'b0010, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
